deck_dealer: RTL and testbench

Card-source controller for the blackjack game. On request it builds a 52-card deck in on-chip registers, Fisher-Yates shuffles it from the 6-bit seed switches, then deals cards one at a time to two requesters, player and house, using round-robin arbitration. It sits between the game controller's hit/stand/deal sequencing and the hand registers, and replaces ad-hoc per-draw random generation.

---
 rtl/deck_pkg.sv | 21 ++
 rtl/deck_lfsr.sv | 35 +++
 rtl/deck_dealer.sv | 199 +++++++++++++++++++
 tb/tb_deck_dealer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deck_pkg.sv
// Shared constants, state encoding and LFSR parameters for the card dealer.
// Imported by deck_lfsr and deck_dealer.
package deck_pkg;

    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned RANK_W    = 4;
    localparam int unsigned SEED_W    = 6;

    // x^6 + x^5 + 1: feedback from the two most significant stages
    localparam logic [SEED_W-1:0] LFSR_TAPS  = 6'b110000;
    localparam logic [SEED_W-1:0] SEED_SUBST = 6'h2D;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StShuffle,
        StReady,
        StDeal
    } deck_state_e;

endpackage

// File: rtl/deck_lfsr.sv
// 6-bit maximal-length Fibonacci LFSR with synchronous load and advance.
// A zero load value is replaced so the register never locks up.
module deck_lfsr
    import deck_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SEED_W-1:0] load_value,
    input  logic              advance,
    output logic [SEED_W-1:0] value
);

    logic [SEED_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (load_value == '0) ? SEED_SUBST : load_value;
        end else if (advance) begin
            value_d = {value_q[SEED_W-2:0], ^(value_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= SEED_SUBST;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/deck_dealer.sv
// Builds a 52-card deck, Fisher-Yates shuffles it from an LFSR, then deals
// cards to player and house with round-robin arbitration.
module deck_dealer
    import deck_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shuffle_req,
    input  logic [SEED_W-1:0] seed,
    input  logic              req_player,
    input  logic              req_house,
    output logic              grant_player,
    output logic              grant_house,
    output logic              card_valid,
    output logic [RANK_W-1:0] card_rank,
    output logic              card_owner,
    output logic              busy,
    output logic              ready,
    output logic [5:0]        cards_left,
    output logic              deck_empty
);

    localparam logic [5:0]        LAST_IDX = 6'(DECK_SIZE - 1);
    localparam logic [5:0]        FULL     = 6'(DECK_SIZE);
    localparam logic [RANK_W-1:0] MAX_RANK = 4'd13;

    deck_state_e state_q, state_d;

    // INIT write pointer k, reused as the Fisher-Yates index i
    logic [5:0]        idx_q, idx_d;
    logic [RANK_W-1:0] init_rank_q, init_rank_d;
    logic [5:0]        top_q, top_d;
    logic [5:0]        left_q, left_d;
    logic              prio_house_q, prio_house_d;

    logic [RANK_W-1:0] deck_q [DECK_SIZE];
    logic [RANK_W-1:0] deck_d [DECK_SIZE];

    logic              grant_player_q, grant_player_d;
    logic              grant_house_q, grant_house_d;
    logic              card_valid_q, card_valid_d;
    logic [RANK_W-1:0] card_rank_q, card_rank_d;
    logic              card_owner_q, card_owner_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              deck_empty_q, deck_empty_d;

    logic              lfsr_load;
    logic              lfsr_advance;
    logic [SEED_W-1:0] lfsr_value;
    logic [5:0]        draw;
    logic              pick_house;

    deck_lfsr u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .load_value (seed),
        .advance    (lfsr_advance),
        .value      (lfsr_value)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        init_rank_d    = init_rank_q;
        top_d          = top_q;
        left_d         = left_q;
        prio_house_d   = prio_house_q;
        deck_d         = deck_q;
        grant_player_d = 1'b0;
        grant_house_d  = 1'b0;
        card_valid_d   = 1'b0;
        card_rank_d    = '0;
        card_owner_d   = 1'b0;
        lfsr_load      = 1'b0;
        lfsr_advance   = 1'b0;
        draw           = lfsr_value - 6'd1;
        pick_house     = req_house && (!req_player || prio_house_q);

        case (state_q)
            StIdle: begin
            end
            StInit: begin
                deck_d[idx_q] = init_rank_q;
                init_rank_d   = (init_rank_q == MAX_RANK) ? 4'd1 : init_rank_q + 4'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = StShuffle;
                    idx_d   = LAST_IDX;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            StShuffle: begin
                lfsr_advance = 1'b1;
                // Draws beyond the unshuffled region are rejected to keep the shuffle unbiased
                if (draw <= idx_q) begin
                    deck_d[idx_q] = deck_q[draw];
                    deck_d[draw]  = deck_q[idx_q];
                    idx_d         = idx_q - 6'd1;
                    if (idx_q == 6'd1) begin
                        state_d = StReady;
                        top_d   = '0;
                        left_d  = FULL;
                    end
                end
            end
            StReady: begin
                if (left_q != '0 && (req_player || req_house)) begin
                    grant_player_d = !pick_house;
                    grant_house_d  = pick_house;
                    card_valid_d   = 1'b1;
                    card_owner_d   = pick_house;
                    card_rank_d    = deck_q[top_q];
                    prio_house_d   = !pick_house;
                    state_d        = StDeal;
                end
            end
            StDeal: begin
                top_d   = top_q + 6'd1;
                left_d  = left_q - 6'd1;
                state_d = StReady;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A rebuild request overrides whatever the current state wanted
        if (shuffle_req) begin
            state_d        = StInit;
            idx_d          = '0;
            init_rank_d    = 4'd1;
            top_d          = '0;
            left_d         = '0;
            lfsr_load      = 1'b1;
            lfsr_advance   = 1'b0;
            grant_player_d = 1'b0;
            grant_house_d  = 1'b0;
            card_valid_d   = 1'b0;
            card_rank_d    = '0;
            card_owner_d   = 1'b0;
        end

        busy_d       = (state_d == StInit) || (state_d == StShuffle);
        ready_d      = (state_d == StReady);
        deck_empty_d = (left_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            init_rank_q    <= 4'd1;
            top_q          <= '0;
            left_q         <= '0;
            prio_house_q   <= 1'b0;
            grant_player_q <= 1'b0;
            grant_house_q  <= 1'b0;
            card_valid_q   <= 1'b0;
            card_rank_q    <= '0;
            card_owner_q   <= 1'b0;
            busy_q         <= 1'b0;
            ready_q        <= 1'b0;
            deck_empty_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            init_rank_q    <= init_rank_d;
            top_q          <= top_d;
            left_q         <= left_d;
            prio_house_q   <= prio_house_d;
            grant_player_q <= grant_player_d;
            grant_house_q  <= grant_house_d;
            card_valid_q   <= card_valid_d;
            card_rank_q    <= card_rank_d;
            card_owner_q   <= card_owner_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            deck_empty_q   <= deck_empty_d;
        end
    end

    // Deck contents are always rebuilt in INIT before use, so no reset needed
    always_ff @(posedge clk) begin
        deck_q <= deck_d;
    end

    assign grant_player = grant_player_q;
    assign grant_house  = grant_house_q;
    assign card_valid   = card_valid_q;
    assign card_rank    = card_rank_q;
    assign card_owner   = card_owner_q;
    assign busy         = busy_q;
    assign ready        = ready_q;
    assign cards_left   = left_q;
    assign deck_empty   = deck_empty_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Scoreboard bench for deck_dealer: stimulus pushes expected cards, a monitor
// pops and compares whenever the dealer presents a card.
module tb_deck_dealer;

    logic       clk = 1'b0;
    logic       rst;
    logic       shuffle_req;
    logic [5:0] seed;
    logic       req_player;
    logic       req_house;
    logic       grant_player;
    logic       grant_house;
    logic       card_valid;
    logic [3:0] card_rank;
    logic       card_owner;
    logic       busy;
    logic       ready;
    logic [5:0] cards_left;
    logic       deck_empty;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q [$];
    logic [3:0] exp_deck [52];
    int         top_m;
    logic [3:0] dealt_seq [64];
    int         dealt_cnt;
    logic [3:0] seqs [5][52];

    deck_dealer dut (
        .clk          (clk),
        .rst          (rst),
        .shuffle_req  (shuffle_req),
        .seed         (seed),
        .req_player   (req_player),
        .req_house    (req_house),
        .grant_player (grant_player),
        .grant_house  (grant_house),
        .card_valid   (card_valid),
        .card_rank    (card_rank),
        .card_owner   (card_owner),
        .busy         (busy),
        .ready        (ready),
        .cards_left   (cards_left),
        .deck_empty   (deck_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_grant_player"}, grant_player, 0);
        check({tag, "_grant_house"}, grant_house, 0);
        check({tag, "_card_valid"}, card_valid, 0);
        check({tag, "_card_rank"}, card_rank, 0);
        check({tag, "_card_owner"}, card_owner, 0);
        check({tag, "_cards_left"}, cards_left, 0);
        check({tag, "_deck_empty"}, deck_empty, 1);
    endtask

    // Reference shuffle: first draw uses the loaded seed, LFSR steps every draw
    task automatic build_model(input logic [5:0] s, output int draws);
        logic [5:0] v;
        logic [3:0] t;
        int         i;
        int         j;
        for (int k = 0; k < 52; k++) exp_deck[k] = 4'((k % 13) + 1);
        v     = (s == 6'h00) ? 6'h2D : s;
        i     = 51;
        draws = 0;
        while (i > 0) begin
            j = int'(v) - 1;
            if (j <= i) begin
                t           = exp_deck[i];
                exp_deck[i] = exp_deck[j];
                exp_deck[j] = t;
                i--;
            end
            v = {v[4:0], v[5] ^ v[4]};
            draws++;
        end
    endtask

    task automatic do_shuffle(input logic [5:0] s, input bit with_house);
        int draws;
        int n;
        build_model(s, draws);
        top_m       = 0;
        seed        = s;
        shuffle_req = 1'b1;
        req_house   = with_house;
        tick();
        shuffle_req = 1'b0;
        req_house   = 1'b0;
        check("busy_after_req", busy, 1);
        check("left_zero_on_busy", cards_left, 0);
        if (with_house) begin
            check("abort_no_grant", grant_house, 0);
            check("abort_no_valid", card_valid, 0);
        end
        n = 1;
        while (!ready && n < 4000) begin
            tick();
            n++;
        end
        check("ready_latency", n, 53 + draws);
        check("left_full", cards_left, 52);
        check("not_empty", deck_empty, 0);
    endtask

    task automatic deal(input bit house);
        int n;
        exp_q.push_back({house, exp_deck[top_m]});
        top_m++;
        if (house) req_house = 1'b1;
        else req_player = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(house ? grant_house : grant_player) && n < 8);
        req_player = 1'b0;
        req_house  = 1'b0;
        check("grant_latency", n, 1);
        tick();
        check("cards_left_count", cards_left, 52 - top_m);
    endtask

    // Monitor
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (card_valid || grant_player || grant_house) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_card actual owner=%0d rank=%0d gp=%0d gh=%0d expected none",
                             card_owner, card_rank, grant_player, grant_house);
                end else begin
                    e = exp_q.pop_front();
                    if ({card_owner, card_rank} !== e || grant_house !== e[4] ||
                        grant_player !== !e[4] || card_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL card actual owner=%0d rank=%0d gp=%0d gh=%0d v=%0d expected owner=%0d rank=%0d",
                                 card_owner, card_rank, grant_player, grant_house, card_valid,
                                 e[4], e[3:0]);
                    end
                    if (dealt_cnt < 64) dealt_seq[dealt_cnt] = card_rank;
                    dealt_cnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        int         diff;
        logic [5:0] det_seeds [5];
        det_seeds = '{6'h11, 6'h11, 6'h00, 6'h2D, 6'h12};

        rst         = 1'b1;
        shuffle_req = 1'b0;
        seed        = 6'h00;
        req_player  = 1'b0;
        req_house   = 1'b0;
        dealt_cnt   = 0;
        top_m       = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Requests in IDLE are ignored
        req_player = 1'b1;
        repeat (4) tick();
        req_player = 1'b0;
        check("idle_ready", ready, 0);

        // Round-robin from reset priority
        do_shuffle(6'h05, 1'b0);
        for (int k = 0; k < 4; k++) exp_q.push_back({k[0], exp_deck[k]});
        top_m      = 4;
        req_player = 1'b1;
        req_house  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("rr_player", grant_player, (g % 2 == 0) ? 1 : 0);
            check("rr_house", grant_house, (g % 2 == 1) ? 1 : 0);
            if (g % 2 == 0) req_player = 1'b0;
            else req_house = 1'b0;
            tick();
            req_player = 1'b1;
            req_house  = 1'b1;
        end
        req_player = 1'b0;
        req_house  = 1'b0;
        check("rr_left", cards_left, 48);

        // Full deck content
        do_shuffle(6'h05, 1'b0);
        dealt_cnt = 0;
        for (int k = 0; k < 52; k++) deal(k % 2 == 1);
        check("empty_flag", deck_empty, 1);
        for (int r = 1; r <= 13; r++) begin
            cnt = 0;
            for (int k = 0; k < 52; k++) if (int'(dealt_seq[k]) == r) cnt++;
            check("rank_tally", cnt, 4);
        end

        // Empty deck refuses requests
        cnt        = 0;
        req_player = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (card_valid || grant_player) cnt++;
        end
        req_player = 1'b0;
        check("empty_no_grant", cnt, 0);
        check("empty_still", deck_empty, 1);
        do_shuffle(6'h09, 1'b0);

        // Determinism
        for (int s = 0; s < 5; s++) begin
            do_shuffle(det_seeds[s], 1'b0);
            dealt_cnt = 0;
            for (int k = 0; k < 52; k++) deal(k % 2 == 1);
            for (int k = 0; k < 52; k++) seqs[s][k] = dealt_seq[k];
        end
        diff = 0;
        for (int k = 0; k < 52; k++) if (seqs[0][k] !== seqs[1][k]) diff++;
        check("det_same_seed", diff, 0);
        diff = 0;
        for (int k = 0; k < 52; k++) if (seqs[2][k] !== seqs[3][k]) diff++;
        check("det_zero_subst", diff, 0);
        diff = 0;
        for (int k = 0; k < 52; k++) if (seqs[4][k] !== seqs[0][k]) diff++;
        check("det_other_seed", (diff != 0) ? 1 : 0, 1);

        // Abort mid-deal, then reset mid-shuffle
        do_shuffle(6'h05, 1'b0);
        for (int k = 0; k < 10; k++) deal(k % 2 == 1);
        check("abort_left_before", cards_left, 42);
        do_shuffle(6'h07, 1'b1);
        seed        = 6'h05;
        shuffle_req = 1'b1;
        tick();
        shuffle_req = 1'b0;
        repeat (60) tick();
        check("mid_shuffle_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_busy", busy, 0);
        check("post_reset_ready", ready, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
